// File: rtl/invz_bus_arbiter_if.sv
// Bus-side signal bundle between the invz arbiter and its driver bank.
//   REQ   : level request per driver (driver-bank control -> arbiter)
//   EN    : one-hot-or-zero enable to invz EN pins (arbiter -> drivers)
//   OWNER : index of the asserted EN bit, 0 when EN is all zero
//   BUSY  : arbiter is in DRIVE or TURN
// master = arbiter side, slave = driver bank / requester side.
interface invz_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] EN;
  logic [OW-1:0]   OWNER;
  logic            BUSY;

  modport master (input REQ, output EN, output OWNER, output BUSY);
  modport slave  (output REQ, input EN, input OWNER, input BUSY);
endinterface

// File: rtl/invz_bus_arbiter.sv
// Round-robin arbiter for NREQ tri-state inverter drivers sharing one net.
// Guarantees at most one EN high and inserts TURN all-zero cycles between
// owners (break-before-make). All outputs are registered; no REQ->EN path.
// Ports:
//   CLK : clock, rising edge
//   RN  : asynchronous reset, active low
//   bus : invz_bus_arbiter_if.master (REQ in; EN, OWNER, BUSY out)
module invz_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 8,
  parameter int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic                  CLK,
  input logic                  RN,
  invz_bus_arbiter_if.master   bus
);

  localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam int TW = $clog2(TURN + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAXHOLD > 0) ? HW'(MAXHOLD - 1) : '0;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN
  } state_t;

  state_t          state;
  logic [NREQ-1:0] en_q;
  logic [OW-1:0]   owner_q;
  logic            busy_q;
  logic [OW-1:0]   ptr;
  logic [HW-1:0]   holdcnt;
  logic [TW-1:0]   turncnt;

  logic            win_valid;
  logic [OW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [OW-1:0]   ptr_next;
  logic            own_req;
  logic            others_req;
  logic            release_now;
  int unsigned     cand;

  // Rotating priority search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_valid && bus.REQ[cand[OW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[OW-1:0];
      end
    end
    if (win_valid) win_onehot[win_idx] = 1'b1;
  end

  assign ptr_next   = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign own_req    = |(bus.REQ & en_q);
  assign others_req = |(bus.REQ & ~en_q);
  // holdcnt saturates at MAXHOLD, so ">=" keeps a requester that shows up
  // after saturation able to preempt a long-running owner.
  assign release_now = !own_req ||
                       ((MAXHOLD != 0) && (holdcnt >= HOLD_LAST) && others_req);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      en_q    <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ptr     <= '0;
      holdcnt <= '0;
      turncnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state   <= ST_DRIVE;
            en_q    <= win_onehot;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
            ptr     <= ptr_next;
            holdcnt <= '0;
          end
        end
        ST_DRIVE: begin
          if (release_now) begin
            state   <= ST_TURN;
            en_q    <= '0;
            owner_q <= '0;
            turncnt <= '0;
          end else if (holdcnt != HOLD_MAX) begin
            holdcnt <= holdcnt + 1'b1;
          end
        end
        ST_TURN: begin
          if (turncnt == TURN_LAST) begin
            if (win_valid) begin
              state   <= ST_DRIVE;
              en_q    <= win_onehot;
              owner_q <= win_idx;
              ptr     <= ptr_next;
              holdcnt <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            turncnt <= turncnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          en_q    <= '0;
          owner_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EN    = en_q;
  assign bus.OWNER = owner_q;
  assign bus.BUSY  = busy_q;

endmodule
